ex3_to_bin_acc: RTL

Downstream stage of the 4-bit binary-to-excess-3 encoder. Consumes a stream of excess-3 decimal digits, most significant digit first, one per handshake. Accumulates NDIG digits into a single unsigned binary value and flags illegal codes. Presents the result on a valid/ready output port for the next stage.

---
 rtl/ex3_pkg.sv | 17 +
 rtl/ex3_digit_dec.sv | 16 +
 rtl/ex3_to_bin_acc.sv | 93 +++++++++
 3 files changed

// File: rtl/ex3_pkg.sv
// rtl/ex3_pkg.sv - shared excess-3 constants, FSM state type and legality check
package ex3_pkg;

   localparam logic [3:0] EX3_OFFSET = 4'd3;
   localparam logic [3:0] EX3_MIN    = 4'h3;
   localparam logic [3:0] EX3_MAX    = 4'hC;

   typedef enum logic {
      ACC  = 1'b0,
      DONE = 1'b1
   } state_t;

   function automatic logic ex3_legal(input logic [3:0] code);
      return (code >= EX3_MIN) && (code <= EX3_MAX);
   endfunction

endpackage

// File: rtl/ex3_digit_dec.sv
// rtl/ex3_digit_dec.sv - combinational excess-3 digit decoder with illegal-code flag
module ex3_digit_dec
   import ex3_pkg::*;
(
   input  logic [3:0] in_ex3,
   output logic [3:0] digit,
   output logic       illegal
);

   // Illegal codes decode to zero so they never perturb the accumulated value.
   always_comb begin
      illegal = !ex3_legal(in_ex3);
      digit   = illegal ? 4'd0 : (in_ex3 - EX3_OFFSET);
   end

endmodule

// File: rtl/ex3_to_bin_acc.sv
// rtl/ex3_to_bin_acc.sv - accumulates NDIG excess-3 digits (MSD first) into a binary value
module ex3_to_bin_acc
   import ex3_pkg::*;
#(
   parameter int NDIG  = 4,
   parameter int OUT_W = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_ex3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_bin,
   output logic             out_err
);

   localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

   if (NDIG < 1) begin : g_bad_ndig
      $error("NDIG must be at least 1");
   end

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [OUT_W-1:0] acc;
   logic             err;

   logic [3:0]       digit;
   logic             illegal;
   logic [OUT_W-1:0] acc_next;

   ex3_digit_dec u_dec (
      .in_ex3  (in_ex3),
      .digit   (digit),
      .illegal (illegal)
   );

   // acc*10 as shift-and-add; the OUT_W sizing rule rules out overflow.
   always_comb begin
      acc_next = (acc << 3) + (acc << 1) + OUT_W'(digit);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACC;
         cnt       <= '0;
         acc       <= '0;
         err       <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_bin   <= '0;
         out_err   <= 1'b0;
      end else begin
         case (state)
            ACC: begin
               if (in_valid) begin
                  acc <= acc_next;
                  err <= err | illegal;
                  if (cnt == LAST) begin
                     out_bin   <= acc_next;
                     out_err   <= err | illegal;
                     cnt       <= '0;
                     state     <= DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               // Result is held until taken; the next number starts from a clean slate.
               if (out_ready) begin
                  acc       <= '0;
                  err       <= 1'b0;
                  state     <= ACC;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= ACC;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
